// File: rtl/note_lane_pkg.sv
// Shared definitions for the note lane engine: FSM encodings, screen geometry
// and the small arithmetic helpers used by the scoring logic.
package note_lane_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b11
    } lane_state_t;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    function automatic logic [31:0] popcount(input logic [31:0] bits);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, bits[i]};
        end
        return n;
    endfunction

    // Counter add that pins at max_val instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] inc,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/note_pattern_ram.sv
// Note pattern storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately left untouched by reset so a song survives an abort.
module note_pattern_ram
    import note_lane_pkg::*;
#(
    parameter int LANES = 3,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [LANES-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [LANES-1:0]         rdata
);

    logic [LANES-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/note_lane_engine.sv
// Rhythm-game lane engine: scrolls pattern rows down the screen, judges lane
// button hits against the hit window and renders the falling notes per pixel.
module note_lane_engine
    import note_lane_pkg::*;
#(
    parameter int LANES   = 3,
    parameter int DEPTH   = 16,
    parameter int STEP    = 1,
    parameter int NOTE_H  = 20,
    parameter int HIT_Y   = 440,
    parameter int HIT_WIN = 16,
    parameter int GAP     = 20,
    parameter int SCORE_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     tick,
    input  logic [LANES-1:0]         hit,
    input  logic                     pat_we,
    input  logic [$clog2(DEPTH)-1:0] pat_addr,
    input  logic [LANES-1:0]         pat_data,
    input  logic [$clog2(DEPTH):0]   pat_len,
    input  logic [9:0]               CounterX,
    input  logic [9:0]               CounterY,
    input  logic                     inDisplayArea,
    output logic [LANES-1:0]         lane_pix,
    output logic [SCORE_W-1:0]       score,
    output logic [SCORE_W-1:0]       miss_cnt,
    output logic [1:0]               state,
    output logic                     done
);

    localparam int AW     = $clog2(DEPTH);
    localparam int LANE_W = H_RES / LANES;
    localparam int HALF_H = NOTE_H / 2;
    localparam logic [AW:0]        LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [SCORE_W-1:0] CNT_MAX = '1;

    lane_state_t        state_q, state_d;
    logic [9:0]         pos_q, pos_d;
    logic [AW-1:0]      row_q, row_d;
    logic [AW:0]        len_q, len_d;
    logic [LANES-1:0]   flags_q, flags_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] miss_q, miss_d;
    logic               done_q, done_d;
    logic [LANES-1:0]   lane_pix_d, lane_pix_p1;

    logic [LANES-1:0]   row_bits;
    logic [LANES-1:0]   good, bad, left_unhit;
    logic [10:0]        pos_next;
    logic [10:0]        y_lo, y_hi;
    logic [31:0]        good_inc, miss_inc;
    logic               in_win, len_ok, last_row, advance, ram_we;

    // Pattern edits are locked out while a song is playing.
    assign ram_we = pat_we && (state_q != ST_PLAY);

    note_pattern_ram #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_pattern (
        .clk   (clk),
        .we    (ram_we),
        .waddr (pat_addr),
        .wdata (pat_data),
        .raddr (row_q),
        .rdata (row_bits)
    );

    // Hit judging always uses the pre-tick position and row.
    assign pos_next   = {1'b0, pos_q} + 11'(STEP);
    assign advance    = tick && (pos_next >= 11'(V_RES));
    assign in_win     = (int'(pos_q) >= HIT_Y - HIT_WIN) && (int'(pos_q) <= HIT_Y + HIT_WIN);
    assign good       = hit & row_bits & ~flags_q & {LANES{in_win}};
    assign bad        = hit & ~good;
    assign left_unhit = row_bits & ~(flags_q | good);
    assign len_ok     = (pat_len != '0) && (pat_len <= LEN_MAX);
    assign last_row   = ({1'b0, row_q} == (len_q - 1'b1));
    assign good_inc   = popcount(32'(good));
    assign miss_inc   = popcount(32'(bad)) + (advance ? popcount(32'(left_unhit)) : 32'd0);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        row_d   = row_q;
        len_d   = len_q;
        flags_d = flags_q;
        score_d = score_q;
        miss_d  = miss_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && len_ok) begin
                    state_d = ST_PLAY;
                    pos_d   = '0;
                    row_d   = '0;
                    len_d   = pat_len;
                    flags_d = '0;
                    score_d = '0;
                    miss_d  = '0;
                end
            end
            ST_PLAY: begin
                flags_d = flags_q | good;
                score_d = SCORE_W'(sat_add(32'(score_q), good_inc, 32'(CNT_MAX)));
                miss_d  = SCORE_W'(sat_add(32'(miss_q), miss_inc, 32'(CNT_MAX)));
                if (tick) begin
                    if (!advance) begin
                        pos_d = pos_next[9:0];
                    end else begin
                        pos_d   = '0;
                        row_d   = row_q + 1'b1;
                        flags_d = '0;
                        if (last_row) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Note body spans position +/- NOTE_H/2; the top edge is clamped at row 0.
    assign y_lo = (pos_q >= 10'(HALF_H)) ? {1'b0, pos_q - 10'(HALF_H)} : 11'd0;
    assign y_hi = {1'b0, pos_q} + 11'(HALF_H);

    always_comb begin
        lane_pix_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (inDisplayArea && (state_q == ST_PLAY) && row_bits[i] && !flags_q[i]
                && (int'(CounterX) >= i * LANE_W)
                && (int'(CounterX) <= (i + 1) * LANE_W - GAP - 1)
                && ({1'b0, CounterY} >= y_lo) && ({1'b0, CounterY} <= y_hi)) begin
                lane_pix_d[i] = 1'b1;
            end
        end
    end

    // p1: registered state, counters and pixel output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            row_q       <= '0;
            len_q       <= '0;
            flags_q     <= '0;
            score_q     <= '0;
            miss_q      <= '0;
            done_q      <= 1'b0;
            lane_pix_p1 <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            row_q       <= row_d;
            len_q       <= len_d;
            flags_q     <= flags_d;
            score_q     <= score_d;
            miss_q      <= miss_d;
            done_q      <= done_d;
            lane_pix_p1 <= lane_pix_d;
        end
    end

    assign lane_pix = lane_pix_p1;
    assign score    = score_q;
    assign miss_cnt = miss_q;
    assign state    = state_q;
    assign done     = done_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Bench for note_lane_engine: directed sequences, a pixel vector table and a
// randomized run, all checked against a behavioural model of the game rules.
module tb_note_lane_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       tick;
    logic [2:0] hit;
    logic       pat_we;
    logic [3:0] pat_addr;
    logic [2:0] pat_data;
    logic [4:0] pat_len;
    logic [9:0] cx;
    logic [9:0] cy;
    logic       de;

    logic [2:0] lane_pix;
    logic [7:0] score;
    logic [7:0] miss_cnt;
    logic [1:0] state;
    logic       done;

    logic [2:0] s_lane_pix;
    logic [1:0] s_score;
    logic [1:0] s_miss;
    logic [1:0] s_state;
    logic       s_done;

    note_lane_engine dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .hit(hit),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data), .pat_len(pat_len),
        .CounterX(cx), .CounterY(cy), .inDisplayArea(de),
        .lane_pix(lane_pix), .score(score), .miss_cnt(miss_cnt), .state(state), .done(done)
    );

    // Narrow-counter copy on the same stimulus, for saturation behaviour.
    note_lane_engine #(.SCORE_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .hit(hit),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data), .pat_len(pat_len),
        .CounterX(cx), .CounterY(cy), .inDisplayArea(de),
        .lane_pix(s_lane_pix), .score(s_score), .miss_cnt(s_miss), .state(s_state), .done(s_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: game state kept as plain integers.
    int       m_state = 0;
    int       m_pos   = 0;
    int       m_row   = 0;
    int       m_len   = 0;
    int       m_score = 0;
    int       m_miss  = 0;
    bit [2:0] m_flags = 0;
    bit [2:0] m_pat [16];
    bit [2:0] e_lane;
    bit       e_done;

    typedef struct {
        int       x;
        int       y;
        bit       en;
        bit [2:0] exp;
    } pix_vec_t;

    pix_vec_t vec [14];

    function automatic int minv(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic model_enter();
        m_state = 1;
        m_pos   = 0;
        m_row   = 0;
        m_len   = pat_len;
        m_flags = 0;
        m_score = 0;
        m_miss  = 0;
    endtask

    // One clock: predict from the rules, clock the DUT, compare everything.
    task automatic cycle();
        bit [2:0] rb;
        int x, y, lo, hi, xl, xr;
        rb     = m_pat[m_row % 16];
        e_lane = 3'b000;
        x      = cx;
        y      = cy;
        if (de && m_state == 1) begin
            for (int i = 0; i < 3; i++) begin
                xl = i * (640 / 3);
                xr = (i + 1) * (640 / 3) - 20 - 1;
                lo = m_pos - 10;
                if (lo < 0) lo = 0;
                hi = m_pos + 10;
                if (rb[i] && !m_flags[i] && x >= xl && x <= xr && y >= lo && y <= hi)
                    e_lane[i] = 1'b1;
            end
        end
        e_done = 1'b0;
        if (m_state != 1) begin
            if (pat_we) m_pat[pat_addr] = pat_data;
            if (start && pat_len >= 1 && pat_len <= 16) model_enter();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (hit[i]) begin
                    if (rb[i] && !m_flags[i] && m_pos >= 440 - 16 && m_pos <= 440 + 16) begin
                        m_score++;
                        m_flags[i] = 1'b1;
                    end else begin
                        m_miss++;
                    end
                end
            end
            if (tick) begin
                if (m_pos + 1 < 480) begin
                    m_pos = m_pos + 1;
                end else begin
                    for (int i = 0; i < 3; i++)
                        if (rb[i] && !m_flags[i]) m_miss++;
                    m_pos   = 0;
                    m_flags = 0;
                    if (m_row == m_len - 1) begin
                        m_state = 3;
                        e_done  = 1'b1;
                    end
                    m_row = m_row + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("state", int'(state), m_state);
        check("score", int'(score), minv(m_score, 255));
        check("miss_cnt", int'(miss_cnt), minv(m_miss, 255));
        check("done", int'(done), int'(e_done));
        check("lane_pix", int'(lane_pix), int'(e_lane));
        check("sat_score", int'(s_score), minv(m_score, 3));
        check("sat_miss", int'(s_miss), minv(m_miss, 3));
    endtask

    task automatic write_row(input int addr, input bit [2:0] data);
        pat_we   = 1'b1;
        pat_addr = 4'(addr);
        pat_data = data;
        cycle();
        pat_we   = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cycle();
        tick = 1'b0;
    endtask

    task automatic pulse_hit(input bit [2:0] h, input bit with_tick);
        hit  = h;
        tick = with_tick;
        cycle();
        hit  = 3'b000;
        tick = 1'b0;
    endtask

    task automatic do_start(input int len);
        pat_len = 5'(len);
        start   = 1'b1;
        cycle();
        start   = 1'b0;
    endtask

    task automatic check_vec(input int i);
        cx = 10'(vec[i].x);
        cy = 10'(vec[i].y);
        de = vec[i].en;
        cycle();
        check($sformatf("vec%0d", i), int'(lane_pix), int'(vec[i].exp));
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_score", int'(score), 0);
        check("rst_miss", int'(miss_cnt), 0);
        check("rst_lane", int'(lane_pix), 0);
        check("rst_done", int'(done), 0);
        check("rst_sat_score", int'(s_score), 0);
        m_state = 0; m_pos = 0; m_row = 0; m_len = 0;
        m_flags = 0; m_score = 0; m_miss = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int dcount;
        int v;

        // pos=5, row 101: clamped note top reaches y=0
        vec[0]  = '{100,   0, 1'b1, 3'b001};
        vec[1]  = '{100,  15, 1'b1, 3'b001};
        vec[2]  = '{100,  16, 1'b1, 3'b000};
        vec[3]  = '{500,   0, 1'b1, 3'b100};
        // pos=440, row 101 with lane 0 already hit
        vec[4]  = '{100, 440, 1'b1, 3'b000};
        vec[5]  = '{500, 440, 1'b1, 3'b100};
        vec[6]  = '{300, 440, 1'b1, 3'b000};
        vec[7]  = '{426, 430, 1'b1, 3'b100};
        vec[8]  = '{618, 450, 1'b1, 3'b100};
        vec[9]  = '{619, 440, 1'b1, 3'b000};
        vec[10] = '{425, 440, 1'b1, 3'b000};
        vec[11] = '{500, 429, 1'b1, 3'b000};
        vec[12] = '{500, 451, 1'b1, 3'b000};
        vec[13] = '{500, 440, 1'b0, 3'b000};

        reset = 1'b1; start = 1'b0; tick = 1'b0; hit = 3'b000;
        pat_we = 1'b0; pat_addr = 4'd0; pat_data = 3'b000; pat_len = 5'd0;
        cx = 10'd0; cy = 10'd0; de = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle();
        check("init_state", int'(state), 0);
        check("init_score", int'(score), 0);
        check("init_lane", int'(lane_pix), 0);

        for (int r = 0; r < 16; r++) write_row(r, 3'($urandom));
        write_row(0, 3'b101);

        // single-row song, hit lane 0 at the line, lane 2 left to fall
        do_start(1);
        ticks(5);
        for (int i = 0; i < 4; i++) check_vec(i);
        ticks(435);
        pulse_hit(3'b001, 1'b0);
        check("req25_score", int'(score), 1);
        for (int i = 4; i < 14; i++) check_vec(i);

        dcount = 0;
        tick = 1'b1;
        for (int i = 0; i < 42; i++) begin
            if (i == 40) tick = 1'b0;
            cycle();
            if (done) dcount++;
        end
        check("req26_done_pulses", dcount, 1);
        check("req26_state", int'(state), 3);
        check("req26_miss", int'(miss_cnt), 1);

        // empty-lane hit
        do_start(1);
        ticks(440);
        pulse_hit(3'b010, 1'b0);
        check("req27_miss", int'(miss_cnt), 1);
        check("req27_score", int'(score), 0);
        ticks(40);

        // window edge, tick coincidence, double hit, multi-lane
        do_start(1);
        ticks(423);
        pulse_hit(3'b001, 1'b1);
        check("req28_early_miss", int'(miss_cnt), 1);
        check("req28_early_score", int'(score), 0);
        pulse_hit(3'b001, 1'b0);
        check("req28_edge_score", int'(score), 1);
        pulse_hit(3'b001, 1'b0);
        check("rehit_miss", int'(miss_cnt), 2);
        pulse_hit(3'b110, 1'b0);
        check("multi_score", int'(score), 2);
        check("multi_miss", int'(miss_cnt), 3);
        ticks(56);
        check("song2_state", int'(state), 3);
        check("song2_miss", int'(miss_cnt), 3);

        // saturation on the 2-bit copy, then abort mid-song
        write_row(0, 3'b111);
        write_row(1, 3'b111);
        write_row(2, 3'b110);
        write_row(3, 3'b111);
        do_start(4);
        ticks(440);
        pulse_hit(3'b111, 1'b0);
        check("sat_score3", int'(s_score), 3);
        ticks(40);
        ticks(440);
        pulse_hit(3'b111, 1'b0);
        check("score6", int'(score), 6);
        check("sat_score_hold", int'(s_score), 3);
        pulse_hit(3'b111, 1'b0);
        pulse_hit(3'b111, 1'b0);
        check("miss6", int'(miss_cnt), 6);
        check("sat_miss_hold", int'(s_miss), 3);
        ticks(40);
        cx = 10'd500; cy = 10'd200; de = 1'b1;
        ticks(200);
        cycle();
        check("pre_reset_lane", int'(lane_pix), 4);
        async_reset();
        repeat (3) cycle();
        check("post_reset_idle", int'(state), 0);
        cx = 10'd100;
        do_start(4);
        ticks(200);
        cycle();
        check("replay_row0_lane", int'(lane_pix), 1);
        check("replay_score", int'(score), 0);

        // randomized play
        for (int n = 0; n < 6000; n++) begin
            tick     = ($urandom_range(0, 9) < 9);
            hit      = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
            start    = ($urandom_range(0, 199) == 0);
            if (m_state != 1) pat_len = 5'($urandom_range(0, 5));
            pat_we   = ($urandom_range(0, 7) == 0);
            pat_addr = 4'($urandom_range(0, 15));
            pat_data = 3'($urandom);
            de       = ($urandom_range(0, 9) != 0);
            cx       = 10'($urandom_range(0, 639));
            if ($urandom_range(0, 1) == 1) begin
                v = m_pos + int'($urandom_range(0, 30)) - 15;
                if (v < 0) v = 0;
                cy = 10'(v);
            end else begin
                cy = 10'($urandom_range(0, 479));
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_lane_engine.md
NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- LANES, 3, number of note lanes.
- DEPTH, 16, pattern rows stored.
- STEP, 1, pixels moved per tick.
- NOTE_H, 20, note height in pixels (even).
- HIT_Y, 440, hit-line row.
- HIT_WIN, 16, half-width of the hit window.
- GAP, 20, blank pixels at the right of each lane.
- SCORE_W, 8, width of the score and miss counters.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, pixel-domain clock.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, level; begins play.
- tick, in, 1, one-cycle scroll strobe.
- hit, in, LANES, one-cycle debounced lane-button pulses.
- pat_we, in, 1, pattern write enable.
- pat_addr, in, clog2(DEPTH), pattern write address.
- pat_data, in, LANES, one bit per lane; 1 means a note is present.
- pat_len, in, clog2(DEPTH)+1, number of rows to play.
- CounterX, in, 10, current pixel column.
- CounterY, in, 10, current pixel row.
- inDisplayArea, in, 1, visible-area flag.
- lane_pix, out, LANES, per-lane pixel-on.
- score, out, SCORE_W, good hits.
- miss_cnt, out, SCORE_W, misses.
- state, out, 2, FSM state.
- done, out, 1, one-cycle end-of-song pulse.

Function
REQ-003 The FSM SHALL have the states IDLE=00, PLAY=01 and DONE=11.
REQ-004 IDLE->PLAY SHALL occur when start=1 and pat_len is in 1..DEPTH; on entry, row_idx=0, position=0, hit flags=0, score=0 and miss_cnt=0.
REQ-005 Writes on pat_we SHALL take effect in IDLE or DONE only, and SHALL be ignored in PLAY.
REQ-006 In PLAY, each tick SHALL compute next=position+STEP.
- If next < 480, position=next.
- Otherwise position=0, row_idx increments, and the hit flags clear.
REQ-007 On a row advance, miss_cnt SHALL increase by the popcount of (row bits AND NOT hit flags) of the row being left.
REQ-008 An advance from row_idx=pat_len-1 SHALL enter DONE and pulse done for exactly one cycle.
REQ-009 DONE->PLAY SHALL occur on start=1 with the same entry actions as REQ-004; with start=0, DONE SHALL hold.
REQ-010 A hit[i] pulse in PLAY SHALL count as good when all of the following hold; it then sets hit flag i and adds 1 to score:
- row bit i=1;
- hit flag i=0;
- position is within [HIT_Y-HIT_WIN, HIT_Y+HIT_WIN].
REQ-011 Any other hit[i] pulse in PLAY SHALL add 1 to miss_cnt, including pulses on an empty lane, outside the window, or on an already-hit note.
REQ-012 Multiple lanes hit in the same cycle SHALL each be judged, and the counters SHALL add the summed increments in that cycle.
REQ-013 When tick and hit coincide, hit SHALL be judged against the pre-tick position and row.
REQ-014 score and miss_cnt SHALL saturate at 2^SCORE_W-1.
REQ-015 Hits and ticks in IDLE or DONE SHALL be ignored.
REQ-016 Lane i SHALL span columns i*(640/LANES) to (i+1)*(640/LANES)-GAP-1, using integer division.
REQ-017 lane_pix[i] SHALL be registered, one clk after the inputs, and SHALL be 1 only when all of the following hold:
- inDisplayArea=1;
- state=PLAY;
- row bit i=1 and hit flag i=0;
- CounterX is inside lane i;
- CounterY is within [max(position-NOTE_H/2,0), position+NOTE_H/2].
REQ-018 The lower bound SHALL be clamped at 0 so that no 10-bit underflow occurs while position < NOTE_H/2.

Reset
REQ-019 Asserting reset SHALL immediately clear the following, independent of clk:
- state=IDLE;
- position=0 and row_idx=0;
- hit flags=0;
- score=0 and miss_cnt=0;
- lane_pix=0 and done=0.
REQ-020 Pattern storage contents SHALL NOT be cleared by reset.
REQ-021 Reset mid-PLAY SHALL abort the song; after release, the block SHALL wait in IDLE for start.

Structure
REQ-022 Shared package note_lane_pkg SHALL hold the following:
- the state encodings;
- H_RES=640 and V_RES=480;
- the popcount and saturating-add functions.
REQ-023 Pattern storage SHALL be the sub-module note_pattern_ram, which is DEPTH x LANES with one synchronous write port and one asynchronous read port at row_idx.
REQ-024 No other sub-modules SHALL be used.

Verification
REQ-025 Load row0=101 and pat_len=1, start, then issue 440 ticks and pulse hit[0]:
- score=1;
- lane_pix[0]=0 on lane-0 pixels at y=440;
- lane_pix[2] remains 1 there.
REQ-026 From REQ-025, issue 40 more ticks: row advance occurs, miss_cnt=1 (lane 2 unhit), done pulses once, and state=DONE.
REQ-027 Pulse hit[1] at position 440 on row bits 101: miss_cnt=1 and score=0.
REQ-028 Pulse hit[0] at position 423 and then at 424: first response miss_cnt=1, second response score=1.
REQ-029 Force score to 255 with SCORE_W=8 and make a good hit: score stays 255.
REQ-030 Assert reset at position=200 in PLAY: all outputs go to zero immediately, state=IDLE, and a subsequent start replays from row 0 with the stored pattern.
